// File: rtl/mole_hit_judge_pkg.sv
// Shared types and helpers for the whack-an-engineer hit judge.
// Holds the judge state enum, the hit-index width helper and the index-to-one-hot decoder.
package mole_pkg;

   typedef enum logic {
      ARMED   = 1'b0,
      LOCKOUT = 1'b1
   } judgeState_t;

   localparam int MAX_HOLES = 15;

   function automatic int hitWidth(input int numHoles);
      return $clog2(numHoles + 1);
   endfunction

   // Index 0 means "no key", so hole k maps to bit k-1.
   function automatic logic [MAX_HOLES-1:0] idx_to_onehot(input logic [3:0] idx);
      logic [MAX_HOLES-1:0] mask;
      mask = '0;
      if (idx != 4'd0) begin
         mask[idx - 4'd1] = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/mole_hit_judge_if.sv
// Strike/score bus between the keyboard decoder, the hit judge and the score/display logic.
// The master modport drives keys and moles; the slave modport is the judge itself.
interface mole_hit_judge_if #(
   parameter int NUM_HOLES = 5,
   parameter int SCORE_W   = 10,
   parameter int STREAK_W  = 4
);
   import mole_pkg::*;

   localparam int HIT_W = hitWidth(NUM_HOLES);

   logic                 enable;
   logic [NUM_HOLES-1:0] moles_up;
   logic [HIT_W-1:0]     hit;
   logic [HIT_W-1:0]     mole_hit;
   logic                 hit_pulse;
   logic                 miss_pulse;
   logic [NUM_HOLES-1:0] clear_mask;
   logic [SCORE_W-1:0]   score;
   logic [SCORE_W-1:0]   miss_count;
   logic                 locked;
   logic [STREAK_W-1:0]  streak;

   modport master (
      output enable, moles_up, hit,
      input  mole_hit, hit_pulse, miss_pulse, clear_mask, score, miss_count, locked, streak
   );

   modport slave (
      input  enable, moles_up, hit,
      output mole_hit, hit_pulse, miss_pulse, clear_mask, score, miss_count, locked, streak
   );

endinterface

// File: rtl/mole_hit_judge_hole_decoder.sv
// Combinational hit-index decoder: turns a key index into a one-hot hole mask.
// Indices above NUM_HOLES raise the out-of-range flag and decode to an empty mask.
module hole_decoder
   import mole_pkg::*;
#(
   parameter int NUM_HOLES = 5,
   parameter int HIT_W     = hitWidth(NUM_HOLES)
) (
   input  logic [HIT_W-1:0]     i_hit,
   output logic [NUM_HOLES-1:0] o_mask,
   output logic                 o_outOfRange
);

   logic [3:0]           w_idx;
   logic [MAX_HOLES-1:0] w_fullMask;
   logic                 w_unusedHigh;

   // Bits beyond the configured hole count are folded into a dummy sink.
   always_comb begin
      w_idx        = 4'(i_hit);
      w_fullMask   = idx_to_onehot(w_idx);
      o_outOfRange = (int'(w_idx) > NUM_HOLES);
      o_mask       = '0;
      w_unusedHigh = 1'b0;
      for (int k = 0; k < NUM_HOLES; k++) begin
         o_mask[k] = w_fullMask[k] & ~o_outOfRange;
      end
      for (int k = NUM_HOLES; k < MAX_HOLES; k++) begin
         w_unusedHigh = w_unusedHigh ^ w_fullMask[k];
      end
   end

endmodule

// File: rtl/mole_hit_judge.sv
// Hit judge: edge-detects strikes, scores hits, penalises misses with a lockout window.
// Optional macro COMBO_BONUS_EN enables the streak counter and the combo bonus.
module mole_hit_judge
   import mole_pkg::*;
#(
   parameter int NUM_HOLES    = 5,
   parameter int SCORE_W      = 10,
   parameter int POINTS       = 1,
   parameter int MISS_PENALTY = 1,
   parameter int LOCKOUT_CYC  = 4,
   parameter int STREAK_W     = 4,
   parameter int COMBO_THRESH = 3
) (
   input logic             clock,
   input logic             reset,
   mole_hit_judge_if.slave bus
);

   localparam int HIT_W = hitWidth(NUM_HOLES);
   localparam int SUM_W = SCORE_W + 8;
   localparam int LC_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   localparam logic [SUM_W-1:0] SCORE_MAX_EXT = {8'd0, {SCORE_W{1'b1}}};

   judgeState_t          r_state;
   logic [LC_W-1:0]      r_lockCount;
   logic [HIT_W-1:0]     r_hitPrev;
   logic                 r_hitPulse;
   logic                 r_missPulse;
   logic [HIT_W-1:0]     r_moleHit;
   logic [NUM_HOLES-1:0] r_clearMask;
   logic [SCORE_W-1:0]   r_score;
   logic [SCORE_W-1:0]   r_missCount;

   judgeState_t          w_nextState;
   logic [LC_W-1:0]      w_nextCount;
   logic                 w_nextHitPulse;
   logic                 w_nextMissPulse;
   logic [HIT_W-1:0]     w_nextMoleHit;
   logic [NUM_HOLES-1:0] w_nextClearMask;
   logic [SCORE_W-1:0]   w_nextScore;
   logic [SCORE_W-1:0]   w_nextMissCount;
   logic [NUM_HOLES-1:0] w_holeMask;
   logic                 w_outOfRange;
   logic                 w_strike;
   logic                 w_holeUp;
   logic [SUM_W-1:0]     w_gain;
   logic [SUM_W-1:0]     w_sum;

`ifdef COMBO_BONUS_EN
   logic [STREAK_W-1:0]  r_streak;
   logic [STREAK_W-1:0]  w_nextStreak;
`endif

   hole_decoder #(
      .NUM_HOLES (NUM_HOLES),
      .HIT_W     (HIT_W)
   ) u_holeDecoder (
      .i_hit        (bus.hit),
      .o_mask       (w_holeMask),
      .o_outOfRange (w_outOfRange)
   );

   // A strike is a fresh in-range key; held keys and out-of-range codes never strike.
   always_comb begin
      w_nextState     = r_state;
      w_nextCount     = r_lockCount;
      w_nextHitPulse  = 1'b0;
      w_nextMissPulse = 1'b0;
      w_nextMoleHit   = '0;
      w_nextClearMask = '0;
      w_nextScore     = r_score;
      w_nextMissCount = r_missCount;
      w_gain          = SUM_W'(POINTS);
      w_sum           = '0;
`ifdef COMBO_BONUS_EN
      w_nextStreak    = r_streak;
`endif
      w_strike = (bus.hit != '0) && !w_outOfRange && (bus.hit != r_hitPrev);
      w_holeUp = |(w_holeMask & bus.moles_up);

      case (r_state)
         ARMED: begin
            if (w_strike && bus.enable) begin
               if (w_holeUp) begin
                  w_nextHitPulse  = 1'b1;
                  w_nextMoleHit   = bus.hit;
                  w_nextClearMask = w_holeMask;
`ifdef COMBO_BONUS_EN
                  w_nextStreak = (r_streak == '1) ? r_streak : r_streak + STREAK_W'(1);
                  if (int'(w_nextStreak) >= COMBO_THRESH) begin
                     w_gain = SUM_W'(2 * POINTS);
                  end
`endif
                  w_sum       = SUM_W'(r_score) + w_gain;
                  w_nextScore = (w_sum > SCORE_MAX_EXT) ? '1 : w_sum[SCORE_W-1:0];
               end else begin
                  w_nextMissPulse = 1'b1;
                  w_nextMissCount = (r_missCount == '1) ? r_missCount
                                                        : r_missCount + SCORE_W'(1);
                  w_nextScore = (SUM_W'(r_score) > SUM_W'(MISS_PENALTY))
                                ? r_score - SCORE_W'(MISS_PENALTY) : '0;
`ifdef COMBO_BONUS_EN
                  w_nextStreak = '0;
`endif
                  if (LOCKOUT_CYC > 0) begin
                     w_nextState = LOCKOUT;
                     w_nextCount = LC_W'(LOCKOUT_CYC - 1);
                  end
               end
            end
         end
         LOCKOUT: begin
            if (r_lockCount == '0) begin
               w_nextState = ARMED;
            end else begin
               w_nextCount = r_lockCount - LC_W'(1);
            end
         end
         default: w_nextState = ARMED;
      endcase
   end

   // State, key history and all visible outputs are registered here.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ARMED;
         r_lockCount <= '0;
         r_hitPrev   <= '0;
         r_hitPulse  <= 1'b0;
         r_missPulse <= 1'b0;
         r_moleHit   <= '0;
         r_clearMask <= '0;
         r_score     <= '0;
         r_missCount <= '0;
`ifdef COMBO_BONUS_EN
         r_streak    <= '0;
`endif
      end else begin
         r_state     <= w_nextState;
         r_lockCount <= w_nextCount;
         r_hitPrev   <= bus.hit;
         r_hitPulse  <= w_nextHitPulse;
         r_missPulse <= w_nextMissPulse;
         r_moleHit   <= w_nextMoleHit;
         r_clearMask <= w_nextClearMask;
         r_score     <= w_nextScore;
         r_missCount <= w_nextMissCount;
`ifdef COMBO_BONUS_EN
         r_streak    <= w_nextStreak;
`endif
      end
   end

   assign bus.mole_hit   = r_moleHit;
   assign bus.hit_pulse  = r_hitPulse;
   assign bus.miss_pulse = r_missPulse;
   assign bus.clear_mask = r_clearMask;
   assign bus.score      = r_score;
   assign bus.miss_count = r_missCount;
   assign bus.locked     = (r_state == LOCKOUT);
`ifdef COMBO_BONUS_EN
   assign bus.streak     = r_streak;
`else
   assign bus.streak     = '0;
`endif

endmodule
